// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the FSM state enum and the source-tag width helper.
package fifo_arb_pkg;

    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer streams plus FIFO write side as seen by the arbiter (slave) and its environment (master).
// With FIFO_ARB_TAG_EN defined, fifo_din carries the grant_id tag above the payload.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int DATA_WIDTH = 24
);
    localparam int ID_WIDTH = id_width(NUM_REQ);
`ifdef FIFO_ARB_TAG_EN
    localparam int OUT_WIDTH = DATA_WIDTH + ID_WIDTH;
`else
    localparam int OUT_WIDTH = DATA_WIDTH;
`endif

    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [OUT_WIDTH-1:0]          fifo_din;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    modport master (
        output in_valid, in_data, fifo_full,
        input  in_ready, fifo_wr_en, fifo_din, grant_id, busy
    );

    modport slave (
        input  in_valid, in_data, fifo_full,
        output in_ready, fifo_wr_en, fifo_din, grant_id, busy
    );

endinterface

// File: rtl/fifo.sv
// Generic single-clock show-ahead FIFO (DEPTH a power of two); dout is valid whenever empty is low.
// Write lands on the write edge; writes while full and reads while empty are ignored.
module fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_wr, do_rd;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wp_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_wr) wp_q <= wp_q + AW'(1);
            if (do_rd) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority selector: first set req bit searching circularly from last+1.
// Purely combinational; any is low when no bit is set (idx then 0).
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any && req[(int'(last) + k) % NUM_REQ]) begin
                idx = ID_WIDTH'((int'(last) + k) % NUM_REQ);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ streams; FIFO_ARB_TAG_EN prepends grant_id to fifo_din.
// Grant 1 cycle after request, words pass combinationally to the FIFO; fifo_full stalls the grantee without releasing it.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int DATA_WIDTH = 24,
    parameter int MAX_BURST  = ARB_MAX_BURST
) (
    input  logic             clk,
    input  logic             reset_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int ID_WIDTH  = id_width(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_q, last_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_any;
    logic                  gnt_vld;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] payload;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req  (bus.in_valid),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign gnt_vld = bus.in_valid[grant_q];
    assign payload = bus.in_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                xfer = gnt_vld && !bus.fifo_full;
                if (xfer) begin
                    beat_d = beat_q + CNT_WIDTH'(1);
                end
                // Full on the last beat is neither a transfer nor a release; a dropped valid always releases.
                if ((xfer && beat_q == LAST_BEAT) || !gnt_vld) begin
                    state_d = RELEASE;
                    last_d  = grant_q;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == GRANT && !bus.fifo_full) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.fifo_wr_en = xfer;
`ifdef FIFO_ARB_TAG_EN
    assign bus.fifo_din   = xfer ? {grant_q, payload} : '0;
`else
    assign bus.fifo_din   = xfer ? payload : '0;
`endif
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q == GRANT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two instances (MAX_BURST 16 and 4) share the producer model.
// Stream i word n carries payload (i << 16) | n.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 24;
`ifdef FIFO_ARB_TAG_EN
    localparam int OW = DW + 2;
`else
    localparam int OW = DW;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [NR-1:0]    in_valid;
    logic [NR*DW-1:0] in_data;
    logic             full_tb, e2e, use4, rd_tick;
    logic             ff_full, ff_empty, ff_rd;
    logic [OW-1:0]    ff_dout;
    wire              full_in = e2e ? ff_full : full_tb;

    int checks = 0;
    int errors = 0;
    int rem [NR];
    int seq [NR];

    logic          s_wr, s_busy;
    logic [NR-1:0] s_rdy;
    logic [1:0]    s_gnt;
    logic [OW-1:0] s_din;
    logic [OW-1:0] got [$];

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if16 ();
    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if4 ();

    assign if16.in_valid  = in_valid;
    assign if16.in_data   = in_data;
    assign if16.fifo_full = full_in;
    assign if4.in_valid   = in_valid;
    assign if4.in_data    = in_data;
    assign if4.fifo_full  = full_in;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .bus(if16));
    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if4));

    assign ff_rd = e2e && rd_tick;
    fifo #(.WIDTH(OW), .DEPTH(8)) u_fifo (
        .clk(clk), .reset_n(reset_n), .wr_en(if4.fifo_wr_en && e2e), .din(if4.fifo_din),
        .full(ff_full), .rd_en(ff_rd), .dout(ff_dout), .empty(ff_empty));

    logic          o_wr, o_busy;
    logic [NR-1:0] o_rdy;
    logic [1:0]    o_gnt;
    logic [OW-1:0] o_din;
    assign o_wr   = use4 ? if4.fifo_wr_en : if16.fifo_wr_en;
    assign o_busy = use4 ? if4.busy       : if16.busy;
    assign o_rdy  = use4 ? if4.in_ready   : if16.in_ready;
    assign o_gnt  = use4 ? if4.grant_id   : if16.grant_id;
    assign o_din  = use4 ? if4.fifo_din   : if16.fifo_din;

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            in_valid[i]          = (rem[i] > 0);
            in_data[i*DW +: DW]  = DW'((i << 16) | seq[i]);
        end
    endtask

    // Sample mid-cycle, then advance the producer model past the next rising edge.
    task automatic cyc();
        @(negedge clk);
        s_wr = o_wr; s_busy = o_busy; s_rdy = o_rdy; s_gnt = o_gnt; s_din = o_din;
        if (ff_rd && !ff_empty) got.push_back(ff_dout);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s_rdy[i] && in_valid[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        full_tb = 1'b0;
        rd_tick = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive();
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NR; i++) rem[i] = 1;
        drive();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks += 10;
        if (if16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy16 got %b want 0", if16.busy); end
        if (if16.in_ready !== 4'b0) begin errors++; $display("FAIL reset_ready16 got %b want 0000", if16.in_ready); end
        if (if16.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr16 got %b want 0", if16.fifo_wr_en); end
        if (if16.fifo_din !== '0) begin errors++; $display("FAIL reset_din16 got %h want 0", if16.fifo_din); end
        if (if16.grant_id !== 2'd0) begin errors++; $display("FAIL reset_gnt16 got %0d want 0", if16.grant_id); end
        if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b want 0", if4.busy); end
        if (if4.in_ready !== 4'b0) begin errors++; $display("FAIL reset_ready4 got %b want 0000", if4.in_ready); end
        if (if4.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr4 got %b want 0", if4.fifo_wr_en); end
        if (if4.fifo_din !== '0) begin errors++; $display("FAIL reset_din4 got %h want 0", if4.fifo_din); end
        if (if4.grant_id !== 2'd0) begin errors++; $display("FAIL reset_gnt4 got %0d want 0", if4.grant_id); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic          exp_wr;
        logic [DW-1:0] exp_d;
        int            k;
        use4 = 1'b0;
        do_reset();
        rem[2] = 20;
        drive();
        k = 0;
        for (int c = 1; c <= 24; c++) begin
            cyc();
            exp_wr = (c >= 2 && c <= 17) || (c >= 20 && c <= 23);
            checks++;
            if (s_wr !== exp_wr) begin errors++; $display("FAIL single_wr c=%0d got %b want %b", c, s_wr, exp_wr); end
            if (exp_wr) begin
                exp_d = DW'((2 << 16) | k);
                k++;
                checks += 2;
                if (s_gnt !== 2'd2) begin errors++; $display("FAIL single_gnt c=%0d got %0d want 2", c, s_gnt); end
                if (s_din[DW-1:0] !== exp_d) begin errors++; $display("FAIL single_din c=%0d got %h want %h", c, s_din[DW-1:0], exp_d); end
            end
        end
        checks++;
        if (rem[2] != 0) begin errors++; $display("FAIL single_left got %0d want 0", rem[2]); end
    endtask

    task automatic test_round_robin();
        logic          exp_wr;
        logic [1:0]    exp_g;
        logic [DW-1:0] exp_d;
        int            b, ph;
        use4 = 1'b1;
        do_reset();
        for (int i = 0; i < NR; i++) rem[i] = 100;
        drive();
        for (int c = 1; c <= 30; c++) begin
            cyc();
            b  = (c - 2) / 6;
            ph = (c - 2) % 6;
            exp_wr = (c >= 2) && (ph < 4);
            checks++;
            if (s_wr !== exp_wr) begin errors++; $display("FAIL rr_wr c=%0d got %b want %b", c, s_wr, exp_wr); end
            if (exp_wr) begin
                exp_g = 2'(b % 4);
                exp_d = DW'((int'(exp_g) << 16) | ((b / 4) * 4 + ph));
                checks += 2;
                if (s_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c=%0d got %0d want %0d", c, s_gnt, exp_g); end
                if (s_din[DW-1:0] !== exp_d) begin errors++; $display("FAIL rr_din c=%0d got %h want %h", c, s_din[DW-1:0], exp_d); end
`ifdef FIFO_ARB_TAG_EN
                checks++;
                if (s_din[OW-1 -: 2] !== exp_g) begin errors++; $display("FAIL rr_tag c=%0d got %0d want %0d", c, s_din[OW-1 -: 2], exp_g); end
`endif
            end
        end
    endtask

    task automatic test_full_stall(input int fs, input int fe, input int last_c);
        logic          exp_wr, exp_busy;
        logic [NR-1:0] exp_rdy;
        use4 = 1'b1;
        do_reset();
        rem[1] = 10;
        drive();
        for (int c = 1; c <= last_c; c++) begin
            full_tb = (c >= fs && c <= fe);
            cyc();
            exp_busy = (c >= 2 && c <= last_c - 1);
            exp_wr   = exp_busy && !(c >= fs && c <= fe);
            exp_rdy  = exp_wr ? 4'b0010 : 4'b0000;
            checks += 3;
            if (s_wr !== exp_wr) begin errors++; $display("FAIL full_wr c=%0d got %b want %b", c, s_wr, exp_wr); end
            if (s_rdy !== exp_rdy) begin errors++; $display("FAIL full_rdy c=%0d got %b want %b", c, s_rdy, exp_rdy); end
            if (s_busy !== exp_busy) begin errors++; $display("FAIL full_busy c=%0d got %b want %b", c, s_busy, exp_busy); end
            if (exp_busy) begin
                checks++;
                if (s_gnt !== 2'd1) begin errors++; $display("FAIL full_gnt c=%0d got %0d want 1", c, s_gnt); end
            end
        end
        full_tb = 1'b0;
    endtask

    task automatic test_drop();
        logic       exp_wr, exp_busy;
        logic [1:0] exp_g;
        use4 = 1'b1;
        do_reset();
        rem[0] = 1;
        rem[3] = 3;
        drive();
        for (int c = 1; c <= 10; c++) begin
            cyc();
            exp_wr   = (c == 2) || (c >= 6 && c <= 8);
            exp_busy = (c == 2) || (c == 3) || (c >= 6 && c <= 9);
            exp_g    = (c <= 3) ? 2'd0 : 2'd3;
            checks += 2;
            if (s_wr !== exp_wr) begin errors++; $display("FAIL drop_wr c=%0d got %b want %b", c, s_wr, exp_wr); end
            if (s_busy !== exp_busy) begin errors++; $display("FAIL drop_busy c=%0d got %b want %b", c, s_busy, exp_busy); end
            if (exp_busy) begin
                checks++;
                if (s_gnt !== exp_g) begin errors++; $display("FAIL drop_gnt c=%0d got %0d want %0d", c, s_gnt, exp_g); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       exp_wr, exp_busy;
        logic [1:0] exp_g;
        use4 = 1'b0;
        do_reset();
        rem[0] = 2;
        rem[1] = 20;
        drive();
        for (int c = 1; c <= 13; c++) begin
            reset_n = (c == 11) ? 1'b0 : 1'b1;
            if (c == 12) begin
                rem[0] = 3;
                drive();
            end
            cyc();
            if (c != 11) begin
                exp_wr   = (c == 2) || (c == 3) || (c >= 7 && c <= 10) || (c == 13);
                exp_busy = exp_wr || (c == 4);
                exp_g    = (c >= 7 && c <= 10) ? 2'd1 : 2'd0;
                checks += 2;
                if (s_wr !== exp_wr) begin errors++; $display("FAIL rmid_wr c=%0d got %b want %b", c, s_wr, exp_wr); end
                if (s_busy !== exp_busy) begin errors++; $display("FAIL rmid_busy c=%0d got %b want %b", c, s_busy, exp_busy); end
                if (exp_busy) begin
                    checks++;
                    if (s_gnt !== exp_g) begin errors++; $display("FAIL rmid_gnt c=%0d got %0d want %0d", c, s_gnt, exp_g); end
                end
            end
            if (c == 12) begin
                checks += 2;
                if (s_rdy !== 4'b0000) begin errors++; $display("FAIL rmid_rdy_after got %b want 0000", s_rdy); end
                if (s_din !== '0) begin errors++; $display("FAIL rmid_din_after got %h want 0", s_din); end
            end
            if (c == 13) begin
                checks += 2;
                if (s_rdy !== 4'b0001) begin errors++; $display("FAIL rmid_rdy_regrant got %b want 0001", s_rdy); end
                if (s_din[DW-1:0] !== 24'h000002) begin errors++; $display("FAIL rmid_din_regrant got %h want 000002", s_din[DW-1:0]); end
            end
        end
    endtask

    task automatic test_e2e();
        int         exp_seq [3];
        logic [7:0] id;
        use4 = 1'b1;
        e2e  = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rem[i]     = 10;
            exp_seq[i] = 0;
        end
        drive();
        got.delete();
        for (int c = 0; c < 600 && got.size() < 30; c++) begin
            rd_tick = (c % 3 == 0);
            cyc();
        end
        rd_tick = 1'b0;
        checks++;
        if (got.size() != 30) begin errors++; $display("FAIL e2e_count got %0d want 30", got.size()); end
        foreach (got[j]) begin
            id = got[j][DW-1:16];
            checks++;
            if (id > 8'd2) begin
                errors++;
                $display("FAIL e2e_src word %0d got %0d want 0..2", j, id);
            end else begin
                checks++;
                if (int'(got[j][15:0]) != exp_seq[id]) begin
                    errors++;
                    $display("FAIL e2e_order src %0d got %0d want %0d", id, got[j][15:0], exp_seq[id]);
                end
                exp_seq[id]++;
`ifdef FIFO_ARB_TAG_EN
                checks++;
                if (got[j][OW-1 -: 2] !== id[1:0]) begin errors++; $display("FAIL e2e_tag word %0d got %0d want %0d", j, got[j][OW-1 -: 2], id[1:0]); end
`endif
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_seq[i] != 10) begin errors++; $display("FAIL e2e_total src %0d got %0d want 10", i, exp_seq[i]); end
        end
        e2e = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        full_tb  = 1'b0;
        e2e      = 1'b0;
        use4     = 1'b0;
        rd_tick  = 1'b0;
        in_valid = '0;
        in_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall(4, 6, 9);
        test_full_stall(5, 5, 7);
        test_drop();
        test_reset_mid();
        test_e2e();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the motion-detection line/frame `fifo` between `NUM_REQ` producer streams. Each stream uses a valid/ready handshake. The block grants one stream at a time for a bounded burst, forwards its words to `fifo` `wr_en`/`din`, and honours `full`. It sits between the pixel producers (background, frame, mask stages) and the shared FIFO's write side; `clk` drives the FIFO's `wr_clk`.

## Interface
- `NUM_REQ`, 4: number of requesting streams (2..16).
- `DATA_WIDTH`, 24: payload width per word.
- `MAX_BURST`, 16: maximum words per grant (1..256).
- `ID_WIDTH`, `$clog2(NUM_REQ)`: source-tag width (localparam).
- `OUT_WIDTH`, `DATA_WIDTH+ID_WIDTH` with tagging, else `DATA_WIDTH` (localparam).

Ports:
- `clk`  in  1  single clock; also drives the FIFO `wr_clk`.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  `NUM_REQ`  per-stream word valid.
- `in_data`  in  `NUM_REQ*DATA_WIDTH`  packed payloads; stream i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`  out  `NUM_REQ`  per-stream accept; one-hot or zero.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_din`  out  `OUT_WIDTH`  FIFO write data.
- `grant_id`  out  `ID_WIDTH`  index of the current grantee; valid while `busy`.
- `busy`  out  1  high in GRANT state.

## Operation
States: IDLE, GRANT, RELEASE.

- **IDLE:** if any `in_valid` is set, select the first set bit searching circularly from `last_grant+1`. Register the result as `grant_id`, clear `beat_cnt`, and move to GRANT. Otherwise stay in IDLE.
- **GRANT:**
  - `in_ready[grant_id] = !fifo_full`; all other ready bits are 0.
  - A transfer occurs when `in_valid[grant_id] && !fifo_full`. On a transfer:
    - `fifo_wr_en = 1`.
    - `fifo_din` = selected payload, with `grant_id` in the MSBs when tagging is enabled.
    - `beat_cnt` increments.
  - Leave for RELEASE, updating `last_grant <= grant_id`, when either:
    - a transfer occurs with `beat_cnt == MAX_BURST-1`, or
    - `in_valid[grant_id]` is low (stream went idle).
  - `fifo_full` alone never releases the grant; the grantee stalls.
- **RELEASE:** one dead cycle with no readies, then return to IDLE. This guarantees fairness and rotation.

Datapath and arithmetic rules:
- `fifo_wr_en` and `in_ready` are combinational from the state register, `grant_id`, `in_valid` and `fifo_full`.
- `fifo_din` is a combinational mux. The FIFO registers it on the same `clk` edge.
- `beat_cnt` width is `$clog2(MAX_BURST+1)` and it never wraps.
- With `MAX_BURST=1`, every transfer releases.

## Timing
- **Reset (`reset_n` low at an edge):**
  - State returns to IDLE; `beat_cnt` = 0; `grant_id` = 0.
  - `last_grant` = `NUM_REQ-1`, so stream 0 has first priority.
  - Outputs: `busy` = 0, `in_ready` = 0, `fifo_wr_en` = 0, `fifo_din` = 0.
  - Reset mid-burst aborts the burst immediately. No partial state survives.
- **Latency:**
  - Request to first grant: 1 cycle. `in_valid` seen in IDLE at edge k gives `in_ready` at cycle k+1.
  - Word accepted at edge n is in the FIFO at the same edge n, with zero added latency.
- **Throughput:** one word per cycle during a burst. The gap between consecutive grants is 2 cycles (RELEASE + IDLE).
- **Handshake rules:**
  - Producers must hold `in_data` stable while `in_valid && !in_ready`.
  - Dropping `in_valid` during a grant is legal and ends the grant.
- **`fifo_full` at an edge:** no write and no ready that cycle. The beat count holds.
- **Simultaneous events:**
  - Full and last beat in the same cycle: no transfer and no release.
  - Grantee drops `in_valid` while `fifo_full` is high: release.
- **Round-robin wrap:** the search from `last_grant+1` wraps at `NUM_REQ-1` to 0.

## Configuration
- **`FIFO_ARB_TAG_EN` defined:**
  - `fifo_din = {grant_id, payload}` and `OUT_WIDTH = DATA_WIDTH+ID_WIDTH`.
  - The read side demultiplexes by tag.
- **Undefined:**
  - `fifo_din = payload` and `OUT_WIDTH = DATA_WIDTH`.
  - `grant_id` is still output, so upstream sideband logic can track the source.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT, RELEASE);
  - the function `id_width(n)` returning `$clog2` clamped to a minimum of 1;
  - the default constants `ARB_NUM_REQ`, `ARB_MAX_BURST`.
- Sub-module `rr_pick`: combinational rotate-priority selector.
  - Inputs: `req[NUM_REQ]`, `last[ID_WIDTH]`.
  - Outputs: `idx`, `any`.
  - Instantiated once and unit-testable on its own.

## Test plan
- **Single requester:** `in_valid=4'b0100` with 20 words, `MAX_BURST=16`, FIFO never full → `grant_id=2`; 16 words written on consecutive cycles; 2-cycle gap; then the remaining 4 words.
- **All four requesting continuously, `MAX_BURST=4`** → grant order 0,1,2,3,0 with 4 writes each. With tagging, the `fifo_din` MSBs match `grant_id`.
- **`fifo_full` asserted for 3 cycles mid-burst (after beat 2)** → `fifo_wr_en` and `in_ready` low for exactly those 3 cycles; the burst then resumes and ends after 4 total beats; the same grantee is kept throughout.
- **Grantee drops `in_valid` after 1 beat while stream 3 is waiting** → RELEASE, IDLE, then grant to 3 two cycles later.
- **Reset pulled low for 1 cycle during beat 5 of stream 1** → next cycle `busy=0`, `in_ready=0`; the first post-reset grant goes to stream 0 when it is requesting.
- **End-to-end with a real `fifo` (depth 8) and a reader:** 3 streams × 10 words → 30 words read out. Per-source order is preserved and nothing is lost or duplicated.
